// File: rtl/fwd_interlock_unit.sv
// Operand forwarding and load-use / HI/LO interlock for the 5-stage MIPS pipeline.
// Resolves ID source operands against producer stages and keeps saturating stall counters.
module fwd_interlock_unit #(
  parameter int NUM_SRC = 2,
  parameter int NUM_STG = 3,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_STG-1:0]     stg_valid,
  input  logic [NUM_STG-1:0]     stg_wen,
  input  logic [NUM_STG-1:0]     stg_ready,
  input  logic [NUM_STG*AW-1:0]  stg_waddr,
  input  logic [NUM_STG*DW-1:0]  stg_wdata,
  input  logic [NUM_SRC-1:0]     src_used,
  input  logic [NUM_SRC*AW-1:0]  src_addr,
  input  logic [NUM_SRC*DW-1:0]  rf_rdata,
  input  logic                   id_valid,
  input  logic                   id_is_mfhilo,
  input  logic                   hilo_start,
  input  logic                   hilo_done,
  input  logic                   cnt_clr,
  output logic [NUM_SRC*DW-1:0]  src_data,
  output logic [NUM_SRC*2-1:0]   src_fwd_sel,
  output logic                   stall,
  output logic                   hilo_busy,
  output logic                   hilo_err,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       hilo_stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hilo_state_t;

  hilo_state_t        state_q, state_d;
  logic               err_d;
  logic [NUM_SRC-1:0] src_pending;
  logic               stall_raw;
  logic               stall_hilo;

  // ---------------------------------------------------------------------------
  // Forwarding: scan oldest to youngest so the youngest matching stage is the
  // last writer and therefore wins. Its ready bit alone decides load-use.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise synthesis infers a latch to hold the old value.
    src_data    = rf_rdata;
    src_fwd_sel = '0;
    src_pending = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int s = NUM_STG - 1; s >= 0; s--) begin
        if (stg_valid[s] && stg_wen[s] &&
            (stg_waddr[s*AW +: AW] == src_addr[i*AW +: AW]) &&
            (src_addr[i*AW +: AW] != '0)) begin
          src_data[i*DW +: DW]   = stg_wdata[s*DW +: DW];
          src_fwd_sel[i*2 +: 2]  = (s >= 2) ? 2'd3 : 2'(s + 1);
          src_pending[i]         = ~stg_ready[s];
        end
      end
    end
  end

  assign stall_raw  = id_valid && |(src_used & src_pending);
  assign stall_hilo = id_valid && id_is_mfhilo && (hilo_busy || hilo_start);
  assign stall      = stall_raw || stall_hilo;

  // ---------------------------------------------------------------------------
  // HI/LO scoreboard. A start while busy keeps the unit busy (the new op is
  // assumed to replace the old one) and flags the overlap as an error.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    err_d   = hilo_err;
    unique case (state_q)
      IDLE: begin
        if (hilo_start) state_d = BUSY;
      end
      BUSY: begin
        if (hilo_start) begin
          state_d = BUSY;
          err_d   = 1'b1;
        end else if (hilo_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      state_q  <= IDLE;
      hilo_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      hilo_err <= err_d;
    end
  end

  assign hilo_busy = (state_q == BUSY);

  // ---------------------------------------------------------------------------
  // Saturating performance counters; clear wins over increment.
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt      <= '0;
      hilo_stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt      <= '0;
      hilo_stall_cnt <= '0;
    end else begin
      if (stall)      stall_cnt      <= sat_inc(stall_cnt);
      if (stall_hilo) hilo_stall_cnt <= sat_inc(hilo_stall_cnt);
    end
  end

endmodule

// File: tb/tb_fwd_interlock_unit.sv
// Scoreboard bench for fwd_interlock_unit: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fwd_interlock_unit;

  localparam int NUM_SRC = 2;
  localparam int NUM_STG = 3;
  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int CNT_W   = 4;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [NUM_STG-1:0]     stg_valid, stg_wen, stg_ready;
  logic [NUM_STG*AW-1:0]  stg_waddr;
  logic [NUM_STG*DW-1:0]  stg_wdata;
  logic [NUM_SRC-1:0]     src_used;
  logic [NUM_SRC*AW-1:0]  src_addr;
  logic [NUM_SRC*DW-1:0]  rf_rdata;
  logic                   id_valid, id_is_mfhilo, hilo_start, hilo_done, cnt_clr;
  logic [NUM_SRC*DW-1:0]  src_data;
  logic [NUM_SRC*2-1:0]   src_fwd_sel;
  logic                   stall, hilo_busy, hilo_err;
  logic [CNT_W-1:0]       stall_cnt, hilo_stall_cnt;

  fwd_interlock_unit #(
    .NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG), .AW(AW), .DW(DW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn),
    .stg_valid(stg_valid), .stg_wen(stg_wen), .stg_ready(stg_ready),
    .stg_waddr(stg_waddr), .stg_wdata(stg_wdata),
    .src_used(src_used), .src_addr(src_addr), .rf_rdata(rf_rdata),
    .id_valid(id_valid), .id_is_mfhilo(id_is_mfhilo),
    .hilo_start(hilo_start), .hilo_done(hilo_done), .cnt_clr(cnt_clr),
    .src_data(src_data), .src_fwd_sel(src_fwd_sel), .stall(stall),
    .hilo_busy(hilo_busy), .hilo_err(hilo_err),
    .stall_cnt(stall_cnt), .hilo_stall_cnt(hilo_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {K_DATA0, K_DATA1, K_SEL0, K_SEL1, K_STALL,
                    K_BUSY, K_ERR, K_SCNT, K_HCNT} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input kind_e k);
    case (k)
      K_DATA0: return src_data[0*DW +: DW];
      K_DATA1: return src_data[1*DW +: DW];
      K_SEL0:  return 32'(src_fwd_sel[1:0]);
      K_SEL1:  return 32'(src_fwd_sel[3:2]);
      K_STALL: return 32'(stall);
      K_BUSY:  return 32'(hilo_busy);
      K_ERR:   return 32'(hilo_err);
      K_SCNT:  return 32'(stall_cnt);
      K_HCNT:  return 32'(hilo_stall_cnt);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compares every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.kind);
      n_checks++;
      if (a !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", e.name, a, e.exp, e.cyc);
      end
    end
  end

  task automatic check(input kind_e k, input logic [31:0] v, input string name);
    q.push_back('{cyc, k, v, name});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stg_valid = '0; stg_wen = '0; stg_ready = '0;
    stg_waddr = '0; stg_wdata = '0;
    src_used = '0; src_addr = '0; rf_rdata = '0;
    id_valid = 1'b0; id_is_mfhilo = 1'b0;
    hilo_start = 1'b0; hilo_done = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic set_stage(input int s, input logic rdy, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    stg_valid[s] = 1'b1; stg_wen[s] = 1'b1; stg_ready[s] = rdy;
    stg_waddr[s*AW +: AW] = a;
    stg_wdata[s*DW +: DW] = d;
  endtask

  task automatic set_src(input int i, input logic used, input logic [AW-1:0] a,
                         input logic [DW-1:0] rf);
    src_used[i] = used;
    src_addr[i*AW +: AW] = a;
    rf_rdata[i*DW +: DW] = rf;
  endtask

  // Load-use pattern: EX loads r7 (not ready), MEM has r7 ready.
  task automatic load_use_on();
    clear_inputs();
    set_stage(0, 1'b0, 5'd7, 32'hDEAD);
    set_stage(1, 1'b1, 5'd7, 32'h77);
    set_src(1, 1'b1, 5'd7, 32'h1234);
    id_valid = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    clear_inputs();
    step();
    step();
    // Reset state
    check(K_BUSY, 0, "rst_busy");
    check(K_ERR,  0, "rst_err");
    check(K_SCNT, 0, "rst_scnt");
    check(K_HCNT, 0, "rst_hcnt");
    check(K_STALL, 0, "rst_stall");
    step();
    resetn = 1'b1;

    // 1) youngest match wins
    step();
    clear_inputs();
    set_stage(0, 1'b1, 5'd5, 32'h11);
    set_stage(1, 1'b1, 5'd5, 32'h22);
    set_src(0, 1'b1, 5'd5, 32'hAAAA);
    set_src(1, 1'b1, 5'd3, 32'hBBBB);
    id_valid = 1'b1;
    check(K_DATA0, 32'h11, "fwd_ex_data");
    check(K_SEL0,  1, "fwd_ex_sel");
    check(K_DATA1, 32'hBBBB, "rf_src1_data");
    check(K_SEL1,  0, "rf_src1_sel");
    check(K_STALL, 0, "fwd_ex_stall");
    step();
    stg_waddr[0*AW +: AW] = 5'd9;
    set_stage(2, 1'b1, 5'd5, 32'h33);
    check(K_DATA0, 32'h22, "fwd_mem_data");
    check(K_SEL0,  2, "fwd_mem_sel");
    step();
    stg_waddr[1*AW +: AW] = 5'd9;
    check(K_DATA0, 32'h33, "fwd_wb_data");
    check(K_SEL0,  3, "fwd_wb_sel");

    // 2) load-use stall and counting
    step(); load_use_on();
    check(K_STALL, 1, "lu_stall_c0");
    check(K_SEL1,  1, "lu_sel");
    check(K_DATA1, 32'hDEAD, "lu_data");
    check(K_SCNT,  0, "lu_scnt_c0");
    step(); check(K_STALL, 1, "lu_stall_c1"); check(K_SCNT, 1, "lu_scnt_c1");
    step(); check(K_STALL, 1, "lu_stall_c2"); check(K_SCNT, 2, "lu_scnt_c2");
    step(); src_used[1] = 1'b0;
    check(K_STALL, 0, "lu_unused_stall"); check(K_SCNT, 3, "lu_scnt_c3");
    step(); src_used[1] = 1'b1; id_valid = 1'b0;
    check(K_STALL, 0, "lu_idinv_stall"); check(K_SCNT, 3, "lu_scnt_c4");
    step(); id_valid = 1'b1; stg_waddr[0*AW +: AW] = 5'd9; stg_ready[1] = 1'b0;
    check(K_STALL, 1, "lu_mem_stall"); check(K_SEL1, 2, "lu_mem_sel");
    step(); clear_inputs(); cnt_clr = 1'b1;
    check(K_SCNT, 4, "lu_scnt_c6");
    step(); cnt_clr = 1'b0;
    check(K_SCNT, 0, "clr_scnt");

    // 3) register 0 never forwards, never stalls
    step(); clear_inputs();
    set_stage(0, 1'b0, 5'd0, 32'hFFFF);
    set_src(0, 1'b1, 5'd0, 32'h0);
    id_valid = 1'b1;
    check(K_DATA0, 0, "r0_data");
    check(K_SEL0,  0, "r0_sel");
    check(K_STALL, 0, "r0_stall");

    // 4) HI/LO interlock
    step(); clear_inputs(); hilo_start = 1'b1;
    check(K_BUSY, 0, "hl_busy_h0"); check(K_STALL, 0, "hl_stall_h0");
    for (int k = 1; k <= 4; k++) begin
      step(); clear_inputs(); id_valid = 1'b1; id_is_mfhilo = 1'b1;
      check(K_BUSY, 1, "hl_busy_mf");
      check(K_STALL, 1, "hl_stall_mf");
      check(K_HCNT, 32'(k - 1), "hl_hcnt_mf");
    end
    step(); clear_inputs(); hilo_done = 1'b1;
    check(K_BUSY, 1, "hl_busy_done"); check(K_STALL, 0, "hl_stall_done");
    check(K_HCNT, 4, "hl_hcnt4");
    step(); clear_inputs();
    check(K_BUSY, 0, "hl_busy_fall"); check(K_SCNT, 4, "hl_scnt4");
    step(); hilo_start = 1'b1; id_valid = 1'b1; id_is_mfhilo = 1'b1;
    check(K_STALL, 1, "hl_stall_start");
    step(); clear_inputs(); hilo_done = 1'b1;
    check(K_BUSY, 1, "hl_busy_h8"); check(K_HCNT, 5, "hl_hcnt5"); check(K_SCNT, 5, "hl_scnt5");
    step();
    check(K_BUSY, 0, "hl_busy_h9");
    step(); clear_inputs();
    check(K_BUSY, 0, "hl_done_idle_ignored");

    // 5) overlap error, sticky, cleared only by reset
    step(); hilo_start = 1'b1;
    check(K_BUSY, 0, "er_busy_e0");
    step();
    check(K_BUSY, 1, "er_busy_e1"); check(K_ERR, 0, "er_err_e1");
    step(); hilo_start = 1'b0;
    check(K_ERR, 1, "er_err_e2"); check(K_BUSY, 1, "er_busy_e2");
    step(); hilo_start = 1'b1; hilo_done = 1'b1;
    check(K_BUSY, 1, "er_busy_e3");
    step(); clear_inputs();
    check(K_BUSY, 1, "er_both_stay_busy"); check(K_ERR, 1, "er_err_sticky");
    step(); clear_inputs(); resetn = 1'b0;
    check(K_BUSY, 0, "rp_busy"); check(K_ERR, 0, "rp_err");
    check(K_SCNT, 0, "rp_scnt"); check(K_HCNT, 0, "rp_hcnt");
    #2 resetn = 1'b1;
    step();
    check(K_BUSY, 0, "rp_busy_after");

    // 6) saturation at 15 and clear priority
    for (int k = 0; k < 18; k++) begin
      step(); load_use_on();
      check(K_SCNT, (k > 15) ? 32'd15 : 32'(k), "sat_scnt");
    end
    step(); cnt_clr = 1'b1;
    check(K_SCNT, 15, "sat_hold"); check(K_STALL, 1, "sat_stall");
    step(); cnt_clr = 1'b0;
    check(K_SCNT, 0, "sat_clr_prio");
    step();
    check(K_SCNT, 1, "sat_restart");
    step(); clear_inputs();

    // Drain the scoreboard, bounded
    for (int k = 0; k < 10 && q.size() > 0; k++) step();
    step();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
